// File: rtl/voice_write_scheduler.sv
`default_nettype none
// ============================================================================
// voice_write_scheduler -- buffers decoded note events in a small FIFO and
// serialises them as acknowledged writes to the voice-parameter port.
// Revision: 1.0
// ============================================================================
module voice_write_scheduler #(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_evt_valid,
    input  logic                        i_evt_note_on,
    input  logic [7:0]                  i_evt_voice,
    input  logic [31:0]                 i_evt_tuning,
    input  logic [6:0]                  i_evt_velocity,
    input  logic                        i_panic,
    input  logic                        i_wr_ack,
    output logic                        o_wr_en,
    output logic [VOICE_W-1:0]          o_wr_voice,
    output logic [31:0]                 o_wr_tuning,
    output logic [6:0]                  o_wr_velocity,
    output logic                        o_wr_gate,
    output logic [NUM_VOICES-1:0]       o_gate_mask,
    output logic [VOICE_W:0]            o_active_count,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_overflow,
    output logic                        o_bad_index
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = VOICE_W + 32 + 7 + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;
    state_t state;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               empty;
    logic               in_range;
    logic               pop;
    logic               push;
    logic               drop_full;
    logic               drop_bad;
    logic [EW-1:0]      evt_entry;
    logic [EW-1:0]      head;
    logic [VOICE_W:0]   gate_pop;

    always_comb begin
        in_range  = ({1'b0, i_evt_voice} < 9'(NUM_VOICES));
        full      = (o_fifo_level == (AW+1)'(FIFO_DEPTH));
        empty     = (o_fifo_level == '0);
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        pop       = (state == ISSUE) && i_wr_ack && !i_panic;
        push      = i_evt_valid && !i_panic && in_range && (!full || pop);
        drop_full = i_evt_valid && !i_panic && in_range && full && !pop;
        drop_bad  = i_evt_valid && !i_panic && !in_range;
        if (i_evt_note_on) begin
            evt_entry = {i_evt_voice[VOICE_W-1:0], i_evt_tuning, i_evt_velocity, 1'b1};
        end else begin
            evt_entry = {i_evt_voice[VOICE_W-1:0], 32'd0, 7'd0, 1'b0};
        end
        head     = mem[rd_ptr];
        gate_pop = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            gate_pop = gate_pop + (VOICE_W+1)'(o_gate_mask[v]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= evt_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_fifo_level   <= '0;
            o_wr_en        <= 1'b0;
            o_wr_voice     <= '0;
            o_wr_tuning    <= '0;
            o_wr_velocity  <= '0;
            o_wr_gate      <= 1'b0;
            o_gate_mask    <= '0;
            o_active_count <= '0;
            o_overflow     <= 1'b0;
            o_bad_index    <= 1'b0;
        end else begin
            o_active_count <= gate_pop;
            if (drop_full) begin
                o_overflow <= 1'b1;
            end
            if (drop_bad) begin
                o_bad_index <= 1'b1;
            end
            if (i_panic) begin
                state        <= IDLE;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                o_fifo_level <= '0;
                o_wr_en      <= 1'b0;
                o_gate_mask  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                o_fifo_level <= o_fifo_level + (AW+1)'(push) - (AW+1)'(pop);
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            {o_wr_voice, o_wr_tuning, o_wr_velocity, o_wr_gate} <= head;
                            o_wr_en <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        // Head entry stays in the FIFO until acknowledged.
                        if (i_wr_ack) begin
                            o_wr_en                 <= 1'b0;
                            o_gate_mask[o_wr_voice] <= o_wr_gate;
                            state                   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
